karatsuba_div_seq: RTL
======================

# karatsuba_div_seq

Sequential restoring divider forming the inverse path of the Karatsuba multiplier. It accepts an N-bit product C and an M-bit operand B, and returns the M-bit quotient Q and remainder R so that C = Q·B + R. It sits beside karatsuba_mul_top and shares its operand widths. Its main uses are recovering operand A from a product, and self-checking multiplier results in the system and in benches.

## Interface
- M, default 32: operand, quotient and remainder width.
- N, default 64: dividend width; must equal 2·M.

Clock and reset:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.

Request side:
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- C  in  N  dividend (product).
- B  in  M  divisor.

Response side:
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- Q  out  M  quotient.
- R  out  M  remainder.
- div_by_zero  out  1  B was 0.
- overflow  out  1  quotient does not fit in M bits.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: one quotient bit per cycle, M cycles.
  - DONE: out_valid=1.
- Accept: in_valid & in_ready in IDLE captures C and B.
  - If B==0: next state DONE with div_by_zero=1, Q=all-ones, R=C[M-1:0].
  - Else if C[N-1:M] >= B: next state DONE with overflow=1, Q=all-ones, R=0.
  - Otherwise: partial remainder (M+1 bits) = C[N-1:M], shift register = C[M-1:0], counter = M-1, next state CALC.
- CALC step:
  - t = {rem[M-1:0], msb of shift register}.
  - If t >= B: rem = t-B and the quotient bit is 1; else rem = t and the quotient bit is 0.
  - The quotient bit shifts into the LSB of Q.
  - Counter decrements; when the counter is 0, go to DONE.
- DONE: Q, R and the flags are held stable while out_valid=1. On out_ready, go to IDLE and clear out_valid.
- Flags are mutually exclusive. Both are 0 for a normal division.
- C and B are ignored outside the IDLE accept cycle. Changing them mid-operation has no effect.

## Timing
- Reset values:
  - in_ready=1 (state IDLE).
  - out_valid=0, Q=0, R=0, div_by_zero=0, overflow=0.
- Normal latency: accept on edge k, out_valid high after edge k+M+1 (M cycles in CALC).
- Zero-divisor and overflow latency: out_valid high after edge k+1.
- in_ready is 0 in CALC and DONE. There is no overlap: the next accept is possible in the first IDLE cycle after the out_ready handshake.
- Minimum request spacing:
  - Normal: M+2 cycles with out_ready tied high.
  - Flagged: 2 cycles.
- Backpressure: out_valid stays high and all outputs are held for any number of cycles until out_ready=1.
- An out_ready asserted while out_valid=0 is ignored.
- Reset asserted in any state returns everything to reset values immediately (asynchronously). An in-flight operation is discarded and produces no output.

## Structure
- Shared package kmul_pkg holds:
  - M and N defaults;
  - the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the counter width $clog2(M).
- The package is reused by karatsuba_mul_top and the benches.
- Sub-module div_step is combinational, one restoring stage: in rem, in bit, in B; out new rem, out q bit. It is instantiated once.
- Top-level holds the FSM, counter, shift registers and handshake logic.

## Test plan
- Simple divide: C=100, B=7 → Q=14, R=2, flags 0, out_valid exactly M+1 cycles after accept.
- Round trip: C = 32'hDB93BBDB × 32'hBBDB83DB, B=32'hBBDB83DB → Q=32'hDB93BBDB, R=0. Repeat with operands 32'h9393BBDB / 32'h83DB03DB and 32'hD39393BB / 32'hFBDBDB03.
- Flag cases:
  - B=0, C=64'h1234 → div_by_zero=1, Q=32'hFFFFFFFF, R=32'h1234, 1-cycle latency.
  - C=64'h0000_0001_0000_0000, B=1 → overflow=1, Q=32'hFFFFFFFF, R=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0. Pulse out_ready → in_ready=1 on the next cycle. An in_valid held high is accepted then.
- Reset mid-CALC: assert rst at cycle 5 of CALC → all outputs at reset values, no out_valid ever appears. After release, a new request C=100, B=7 completes correctly.
- Random: 1000 random A, B≠0, with C=A·B+r (r<B) → Q=A, R=r, checked against a reference model.

Source files
------------

// File: rtl/kmul_pkg.sv
// kmul_pkg: shared definitions for the Karatsuba multiplier/divider family.
// Holds default operand widths, the divider state encoding and a helper that
// sizes the bit counter for a given operand width.
`timescale 1ns/1ps
package kmul_pkg;

  localparam int unsigned M_DEF = 32;  // operand / quotient / remainder width
  localparam int unsigned N_DEF = 64;  // dividend (product) width, always 2*M

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must hold M-1; guard M=1 so the width never collapses to zero.
  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(M_DEF);

endpackage

// File: rtl/karatsuba_div_seq_if.sv
// karatsuba_div_seq_if: request/response bundle of the sequential divider.
//   request : in_valid, in_ready, C (N-bit dividend), B (M-bit divisor)
//   response: out_valid, out_ready, Q, R (M-bit), div_by_zero, overflow
// master = requester (drives the request, consumes the response)
// slave  = the divider
`timescale 1ns/1ps
interface karatsuba_div_seq_if
  import kmul_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned N = N_DEF
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] C;
  logic [M-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] Q;
  logic [M-1:0] R;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output in_valid, C, B, out_ready,
    input  in_ready, out_valid, Q, R, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, C, B, out_ready,
    output in_ready, out_valid, Q, R, div_by_zero, overflow
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division stage.
//   rem      in  M  partial remainder (always < b, so M bits suffice)
//   bit_in   in  1  next dividend bit shifted in below the remainder
//   b        in  M  divisor
//   rem_next out M  remainder after the trial subtraction
//   q_bit    out 1  quotient bit (1 when the subtraction was kept)
`timescale 1ns/1ps
module div_step
  import kmul_pkg::*;
#(
  parameter int unsigned M = M_DEF
) (
  input  logic [M-1:0] rem,
  input  logic         bit_in,
  input  logic [M-1:0] b,
  output logic [M-1:0] rem_next,
  output logic         q_bit
);

  logic [M:0] t;

  assign t     = {rem, bit_in};
  assign q_bit = (t >= {1'b0, b});
  // When t >= b the difference is < b < 2^M, so the low M bits are exact.
  assign rem_next = q_bit ? (t[M-1:0] - b) : t[M-1:0];

endmodule

// File: rtl/karatsuba_div_seq.sv
// karatsuba_div_seq: sequential restoring divider, C = Q*B + R.
// One quotient bit per cycle in CALC; divide-by-zero and quotient overflow
// are detected at accept time and go straight to DONE.
//   clk, rst  clock, asynchronous active-high reset
//   bus       slave side of karatsuba_div_seq_if (request + response)
`timescale 1ns/1ps
module karatsuba_div_seq
  import kmul_pkg::*;
#(
  parameter int unsigned M = M_DEF,
  parameter int unsigned N = N_DEF
) (
  input logic                  clk,
  input logic                  rst,
  karatsuba_div_seq_if.slave   bus
);

  localparam int unsigned CW = cnt_width(M);

  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  rem_q, rem_d;   // partial remainder; doubles as R in DONE
  logic [M-1:0]  sh_q, sh_d;     // low dividend half, consumed MSB first
  logic [M-1:0]  quo_q, quo_d;
  logic [M-1:0]  b_q, b_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [M-1:0]  step_rem;
  logic          step_q;

  div_step #(
    .M (M)
  ) u_step (
    .rem      (rem_q),
    .bit_in   (sh_q[M-1]),
    .b        (b_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    quo_d   = quo_q;
    b_d     = b_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          b_d   = bus.B;
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          if (bus.B == '0) begin
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = bus.C[M-1:0];
            state_d = DONE;
          end else if (bus.C[N-1:M] >= bus.B) begin
            // Quotient would need more than M bits.
            ovf_d   = 1'b1;
            quo_d   = '1;
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = bus.C[N-1:M];
            sh_d    = bus.C[M-1:0];
            quo_d   = '0;
            cnt_d   = CW'(M - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        sh_d  = {sh_q[M-2:0], 1'b0};
        quo_d = {quo_q[M-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      quo_q   <= '0;
      b_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.Q           = quo_q;
  assign bus.R           = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
